// File: rtl/rv_core_pkg.sv
// Shared constants for the RV32I core front end.
package rv_core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] RV_NOP  = 32'h0000_0013;
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus: instruction-memory request/response, redirect and decode handoff.
interface fetch_queue_unit_if #(
    parameter int unsigned XLEN = rv_core_pkg::XLEN
) ();

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    // Fetch unit side.
    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_instr,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    // Memory / decode / branch-unit side.
    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_instr,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear, occupancy count and registered storage.
// Read data is zero when empty; push while full is only honoured with a same-cycle pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Status, qualified handshakes and head read-out.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        count   = count_q;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Pointers and occupancy; clear wins over push and pop.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (reset && !clear && do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Pipelined instruction fetch with a credit-limited prefetch queue and redirect flush.
// Credits cover queued plus in-flight fetches, so a returning response always has a slot.
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = rv_core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    fetch_queue_unit_if.master  bus
);

    import rv_core_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]   fetch_pc_q;
    logic [XLEN-1:0]   rsp_pc_q;
    logic [CW-1:0]     outstanding_q;
    logic [CW-1:0]     outstanding_d;
    logic [CW-1:0]     discard_q;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW:0]       credit_used;
    logic              req_fire;
    logic              rsp_keep;
    logic              pop;
    logic [XLEN-1:0]   redirect_aligned;
    logic [2*XLEN-1:0] head;

    // Request credit, handshake qualification and outstanding next-state.
    always_comb begin
        credit_used        = {1'b0, outstanding_q} + {1'b0, fifo_count};
        bus.imem_req_valid = reset && !bus.redirect_valid && !fifo_full && (credit_used < CREDITS);
        bus.imem_req_addr  = fetch_pc_q;
        req_fire           = bus.imem_req_valid && bus.imem_req_ready;
        rsp_keep           = bus.imem_rsp_valid && !bus.redirect_valid && (discard_q == '0);
        bus.instr_valid    = reset && !fifo_empty;
        pop                = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
        bus.instr_pc       = head[2*XLEN-1:XLEN];
        bus.instr          = head[XLEN-1:0];
        redirect_aligned   = {bus.redirect_pc[XLEN-1:2], 2'b00};
        outstanding_d      = outstanding_q;
        if (req_fire && !bus.imem_rsp_valid) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!req_fire && bus.imem_rsp_valid) begin
            outstanding_d = outstanding_q - CW'(1);
        end
    end

    // PC, outstanding and discard tracking; redirect takes priority over normal flow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (bus.redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                discard_q  <= outstanding_d;
                fetch_pc_q <= redirect_aligned;
                rsp_pc_q   <= redirect_aligned;
            end else begin
                if (req_fire) begin
                    fetch_pc_q <= fetch_pc_q + XLEN'(PC_STEP);
                end
                if (bus.imem_rsp_valid && (discard_q != '0)) begin
                    discard_q <= discard_q - CW'(1);
                end
                if (rsp_keep) begin
                    rsp_pc_q <= rsp_pc_q + XLEN'(PC_STEP);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_keep),
        .pop   (pop),
        .clear (bus.redirect_valid),
        .wdata ({rsp_pc_q, bus.imem_rsp_instr}),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level model (queue of fetched items,
// list of in-flight requests tagged live/dead) plus a latency-configurable memory model.
module tb_fetch_queue_unit;

    import rv_core_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct { bit live; logic [31:0] addr; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } qent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        bit          rst_first;
        bit          ir;
        bit          rr;
        bit          exp_rv;
        logic [31:0] exp_addr;
        bit          exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    logic clk;
    logic reset;

    fetch_queue_unit_if #(.XLEN(32)) bus ();

    fetch_queue_unit #(
        .XLEN     (32),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 1;
    bit          rst     = 1'b0;
    bit          ir      = 1'b1;
    bit          rr      = 1'b1;
    bit          rsp_v;
    bit          exp_rv;
    bit          cur_redir;
    logic [31:0] cur_rpc;
    logic [31:0] fetch_pc = RESET_PC;
    infl_t       infl[$];
    qent_t       mq[$];
    mreq_t       pend[$];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive this cycle's inputs, let them settle, compare outputs with the model.
    task automatic apply(input bit redir, input logic [31:0] rpc);
        reset              = rst;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.instr_ready    = ir;
        bus.imem_req_ready = rr;
        cur_redir          = redir;
        cur_rpc            = rpc;
        rsp_v              = rst && (pend.size() > 0) && (pend[0].due == cyc);
        bus.imem_rsp_valid = rsp_v;
        bus.imem_rsp_instr = rsp_v ? mem_word(pend[0].addr) : RV_NOP;
        #1;
        exp_rv = rst && !redir && ((infl.size() + mq.size()) < DEPTH);
        check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", bus.imem_req_addr, fetch_pc);
        check("instr_valid", 32'(bus.instr_valid), 32'(rst && mq.size() > 0));
        if (rst) begin
            check("instr_pc", bus.instr_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
            check("instr", bus.instr, (mq.size() > 0) ? mq[0].instr : 32'h0);
            check("queue_count", 32'(dut.fifo_count), 32'(mq.size()));
            n_tests++;
            if (int'(dut.fifo_count) > DEPTH) begin
                n_fail++;
                $display("FAIL overflow: got count %0d limit %0d", dut.fifo_count, DEPTH);
            end
        end
    endtask

    // Advance model and memory to the next cycle, then cross the clock edge.
    task automatic finish();
        bit    pop_m;
        infl_t ie;
        mreq_t me;
        pop_m = rst && (mq.size() > 0) && ir;
        if (!rst) begin
            infl.delete();
            mq.delete();
            pend.delete();
            fetch_pc = RESET_PC;
        end else begin
            if (rsp_v) me = pend.pop_front();
            if (cur_redir) begin
                mq.delete();
                if (rsp_v && infl.size() > 0) ie = infl.pop_front();
                foreach (infl[i]) infl[i].live = 1'b0;
                fetch_pc = cur_rpc & ~32'h3;
            end else begin
                if (pop_m) void'(mq.pop_front());
                if (rsp_v && infl.size() > 0) begin
                    ie = infl.pop_front();
                    if (ie.live) mq.push_back('{pc: ie.addr, instr: mem_word(ie.addr)});
                end
            end
            if (exp_rv && rr) begin
                infl.push_back('{live: 1'b1, addr: fetch_pc});
                fetch_pc = fetch_pc + PC_STEP;
            end
            if (bus.imem_req_valid && rr) pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle(input bit redir, input logic [31:0] rpc);
        apply(redir, rpc);
        finish();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        rst = 1'b1;
    endtask

    // Wait (bounded) for the first presented instruction and check its PC.
    task automatic expect_first_pc(input string name, input logic [31:0] pc);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            apply(1'b0, 32'h0);
            if (bus.instr_valid) begin
                seen = 1'b1;
                check(name, bus.instr_pc, pc);
            end
            finish();
        end
        if (!seen) check({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    vec_t tbl [16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;

        // Streaming from reset, then decode stall with credit exhaustion and resume.
        tbl[0]  = '{1, 1, 1, 1, 32'h00, 0, 32'h00};
        tbl[1]  = '{0, 1, 1, 1, 32'h04, 0, 32'h00};
        tbl[2]  = '{0, 1, 1, 1, 32'h08, 1, 32'h00};
        tbl[3]  = '{0, 1, 1, 1, 32'h0C, 1, 32'h04};
        tbl[4]  = '{0, 1, 1, 1, 32'h10, 1, 32'h08};
        tbl[5]  = '{1, 0, 1, 1, 32'h00, 0, 32'h00};
        tbl[6]  = '{0, 0, 1, 1, 32'h04, 0, 32'h00};
        tbl[7]  = '{0, 0, 1, 1, 32'h08, 1, 32'h00};
        tbl[8]  = '{0, 0, 1, 1, 32'h0C, 1, 32'h00};
        tbl[9]  = '{0, 0, 1, 0, 32'h00, 1, 32'h00};
        tbl[10] = '{0, 0, 1, 0, 32'h00, 1, 32'h00};
        tbl[11] = '{0, 1, 1, 0, 32'h00, 1, 32'h00};
        tbl[12] = '{0, 1, 1, 1, 32'h10, 1, 32'h04};
        tbl[13] = '{0, 1, 1, 1, 32'h14, 1, 32'h08};
        tbl[14] = '{0, 1, 1, 1, 32'h18, 1, 32'h0C};
        tbl[15] = '{0, 1, 1, 1, 32'h1C, 1, 32'h10};

        lat = 1;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst_first) do_reset();
            ir = tbl[i].ir;
            rr = tbl[i].rr;
            apply(1'b0, 32'h0);
            check("tbl_req_valid", 32'(bus.imem_req_valid), 32'(tbl[i].exp_rv));
            if (tbl[i].exp_rv) check("tbl_req_addr", bus.imem_req_addr, tbl[i].exp_addr);
            check("tbl_instr_valid", 32'(bus.instr_valid), 32'(tbl[i].exp_iv));
            if (tbl[i].exp_iv) check("tbl_instr_pc", bus.instr_pc, tbl[i].exp_pc);
            finish();
        end

        // Memory not ready for 5 cycles: address holds, outstanding tracks the model.
        held = fetch_pc;
        rr   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 32'h0);
            check("stall_addr", bus.imem_req_addr, held);
            check("stall_outstanding", 32'(dut.outstanding_q), 32'(infl.size()));
            finish();
        end
        rr = 1'b1;
        for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0);

        // 3-cycle memory: redirect to 0x102 with 2 in flight and 1 queued.
        lat = 3;
        ir  = 1'b0;
        rr  = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0);
        rr = 1'b0;
        cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_0102);
        rr = 1'b1;
        apply(1'b0, 32'h0);
        check("redir_addr", bus.imem_req_addr, 32'h0000_0100);
        check("redir_flushed", 32'(bus.instr_valid), 32'h0);
        finish();
        ir = 1'b1;
        expect_first_pc("redir_first_pc", 32'h0000_0100);

        // Redirect to 0x40 in the cycle the 0x8 response returns.
        lat = 1;
        ir  = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_0040);
        expect_first_pc("redir_same_rsp_pc", 32'h0000_0040);

        // Reset mid-operation abandons queued and in-flight fetches.
        lat = 3;
        ir  = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b0, 32'h0);
        rst = 1'b0;
        cycle(1'b0, 32'h0);
        apply(1'b0, 32'h0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        finish();
        rst = 1'b1;
        apply(1'b0, 32'h0);
        check("rst_first_addr", bus.imem_req_addr, RESET_PC);
        check("rst_first_valid", 32'(bus.imem_req_valid), 32'h1);
        finish();

        // Randomized traffic against the model across memory latencies.
        for (int l = 1; l <= 3; l++) begin
            lat = l;
            do_reset();
            for (int k = 0; k < 600; k++) begin
                ir  = ($urandom_range(0, 3) != 0);
                rr  = ($urandom_range(0, 3) != 0);
                rst = ($urandom_range(0, 299) != 0);
                cycle(($urandom_range(0, 15) == 0), $urandom);
            end
            rst = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
